// File: rtl/ysyx_25020047_lsu_if.sv
// ysyx_25020047_lsu_if: request/response memory bus between the LSU (master) and memory (slave).
interface ysyx_25020047_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );
    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: multi-cycle load/store unit (IDLE/REQ/WAIT/DONE) between EXU and WBU.
// Define YSYX_25020047_LSU_ALIGN_CHECK_EN to trap misaligned lw/sw instead of issuing them word-aligned.
module ysyx_25020047_lsu (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [31:0]                   i_inst_type,
    input  logic [31:0]                   i_result,
    input  logic [31:0]                   i_rdata2,
    input  logic                          i_reg_wen,
    input  logic                          i_read,
    input  logic                          i_write,
    ysyx_25020047_lsu_if.master           mem,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [31:0]                   o_out_data,
    output logic                          o_out_reg_wen,
    output logic                          o_out_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [31:0] r_out_data;
    logic        r_out_reg_wen;
    logic        r_err;
    logic        r_read;
    logic        r_lbu;
    logic [1:0]  r_off;
    logic        w_sb;
    logic        w_mis;
    logic [7:0]  w_byte;

    assign w_sb   = i_inst_type == 32'h100;
    assign w_byte = mem.mem_rdata[{r_off, 3'b000} +: 8];
`ifdef YSYX_25020047_LSU_ALIGN_CHECK_EN
    assign w_mis  = (i_inst_type == 32'h20 || i_inst_type == 32'h80) && (i_result[1:0] != 2'b00);
`else
    assign w_mis  = 1'b0;
`endif

    assign o_in_ready        = r_state == S_IDLE;
    assign o_out_valid       = r_state == S_DONE;
    assign o_out_data        = r_out_data;
    assign o_out_reg_wen     = r_out_reg_wen;
    assign o_out_err         = r_err;
    assign mem.mem_req_valid = r_state == S_REQ;
    assign mem.mem_addr      = r_addr;
    assign mem.mem_wen       = r_wen;
    assign mem.mem_wdata     = r_wdata;
    assign mem.mem_wmask     = r_wmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= 32'h0;
            r_wen         <= 1'b0;
            r_wdata       <= 32'h0;
            r_wmask       <= 4'h0;
            r_out_data    <= 32'h0;
            r_out_reg_wen <= 1'b0;
            r_err         <= 1'b0;
            r_read        <= 1'b0;
            r_lbu         <= 1'b0;
            r_off         <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: if (i_in_valid) begin
                    r_out_data    <= i_result;
                    r_err         <= w_mis;
                    r_out_reg_wen <= i_reg_wen && !i_write && !w_mis;
                    r_read        <= i_read;
                    r_lbu         <= i_inst_type == 32'h40;
                    r_off         <= i_result[1:0];
                    if (!w_mis && (i_read || i_write)) begin
                        r_state <= S_REQ;
                        r_addr  <= {i_result[31:2], 2'b00};
                        r_wen   <= i_write;
                        r_wdata <= w_sb ? {4{i_rdata2[7:0]}} : i_rdata2;
                        r_wmask <= !i_write ? 4'h0 : w_sb ? 4'b0001 << i_result[1:0] : 4'hF;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_REQ:  if (mem.mem_req_ready) r_state <= S_WAIT;
                S_WAIT: if (mem.mem_resp_valid) begin
                    if (r_read) r_out_data <= r_lbu ? {24'h0, w_byte} : mem.mem_rdata;
                    r_state <= S_DONE;
                end
                default: if (i_out_ready) r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// tb_ysyx_25020047_lsu: directed vectors for the LSU; inputs driven and outputs sampled on negedge.
module tb_ysyx_25020047_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst_type = 32'h0;
    logic [31:0] result = 32'h0;
    logic [31:0] rdata2 = 32'h0;
    logic        reg_wen = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_reg_wen;
    logic        out_err;
    int          n_tot = 0;
    int          n_bad = 0;

    ysyx_25020047_lsu_if bus ();

    ysyx_25020047_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_inst_type  (inst_type),
        .i_result     (result),
        .i_rdata2     (rdata2),
        .i_reg_wen    (reg_wen),
        .i_read       (rd),
        .i_write      (wr),
        .mem          (bus.master),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_reg_wen(out_reg_wen),
        .o_out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [31:0] it, input logic [31:0] res, input logic [31:0] d2,
                          input logic wen, input logic r, input logic w);
        @(negedge clk);
        in_valid = 1'b1; inst_type = it; result = res; rdata2 = d2; reg_wen = wen; rd = r; wr = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic serve(input logic [31:0] data);
        @(negedge clk);
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = data;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
    endtask

    initial begin
        bus.mem_req_ready = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata = 32'h0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_wmask", 32'(bus.mem_wmask), 32'h0);
        chk("rst_err", 32'(out_err), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        accept(32'h1, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("alu_valid", 32'(out_valid), 32'h1);
        chk("alu_data", out_data, 32'h1234);
        chk("alu_wen", 32'(out_reg_wen), 32'h1);
        chk("alu_noreq", 32'(bus.mem_req_valid), 32'h0);
        @(negedge clk);
        chk("alu_idle", 32'(in_ready), 32'h1);

        accept(32'h100, 32'h8000_0003, 32'hAB, 1'b0, 1'b0, 1'b1);
        chk("sb_req", 32'(bus.mem_req_valid), 32'h1);
        chk("sb_addr", bus.mem_addr, 32'h8000_0000);
        chk("sb_mask", 32'(bus.mem_wmask), 32'h8);
        chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        chk("sb_wen", 32'(bus.mem_wen), 32'h1);
        serve(32'h0);
        chk("sb_valid", 32'(out_valid), 32'h1);
        chk("sb_regwen", 32'(out_reg_wen), 32'h0);
        chk("sb_data", out_data, 32'h8000_0003);

        accept(32'h40, 32'h8000_0002, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("lbu_mask", 32'(bus.mem_wmask), 32'h0);
        chk("lbu_wen", 32'(bus.mem_wen), 32'h0);
        serve(32'h1122_3344);
        chk("lbu_data", out_data, 32'h0000_0022);
        chk("lbu_regwen", 32'(out_reg_wen), 32'h1);

        accept(32'h20, 32'h8000_0004, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("lw_addr", bus.mem_addr, 32'h8000_0004);
        serve(32'hDEAD_BEEF);
        chk("lw_data", out_data, 32'hDEAD_BEEF);

        bus.mem_req_ready = 1'b0;
        accept(32'h20, 32'h8000_0008, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_req", 32'(bus.mem_req_valid), 32'h1);
            chk("bp_addr", bus.mem_addr, 32'h8000_0008);
            chk("bp_inrdy", 32'(in_ready), 32'h0);
            if (i < 2) @(negedge clk);
        end
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_wait_req", 32'(bus.mem_req_valid), 32'h0);
            chk("bp_wait_out", 32'(out_valid), 32'h0);
        end
        out_ready = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_data", out_data, 32'hCAFE_F00D);
            chk("bp_out_inrdy", 32'(in_ready), 32'h0);
            if (i < 1) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(in_ready), 32'h1);

        accept(32'h80, 32'h8000_0002, 32'h55, 1'b0, 1'b0, 1'b1);
`ifdef YSYX_25020047_LSU_ALIGN_CHECK_EN
        chk("mis_valid", 32'(out_valid), 32'h1);
        chk("mis_err", 32'(out_err), 32'h1);
        chk("mis_noreq", 32'(bus.mem_req_valid), 32'h0);
        chk("mis_data", out_data, 32'h8000_0002);
        chk("mis_regwen", 32'(out_reg_wen), 32'h0);
        @(negedge clk);
`else
        chk("mis_req", 32'(bus.mem_req_valid), 32'h1);
        chk("mis_addr", bus.mem_addr, 32'h8000_0000);
        chk("mis_mask", 32'(bus.mem_wmask), 32'hF);
        chk("mis_wdata", bus.mem_wdata, 32'h55);
        serve(32'h0);
        chk("mis_err", 32'(out_err), 32'h0);
        @(negedge clk);
`endif

        accept(32'h20, 32'h8000_0010, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.mem_req_valid), 32'h0);
        chk("arst_addr", bus.mem_addr, 32'h0);
        chk("arst_inrdy", 32'(in_ready), 32'h1);
        chk("arst_out", 32'(out_valid), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("late_resp_out", 32'(out_valid), 32'h0);
            chk("late_resp_data", out_data, 32'h0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
